id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 126 ++++++++++++
 tb/tb_id_ex_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and saturating bubble/flush counters; 1-cycle latency.
// Backpressure: stall_in freezes EX and counters; stall_in or a load-use hazard drops PCWrite/IFID_Write.
module id_ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_in,
    input  logic                  flush,
    input  logic                  ID_valid,
    input  logic [4:0]            ID_Rs,
    input  logic [4:0]            ID_Rt,
    input  logic [4:0]            ID_Rd,
    input  logic                  ID_RegDst,
    input  logic                  ID_RegWrite,
    input  logic                  ID_MemRead,
    input  logic                  ID_MemWrite,
    input  logic                  ID_MemToReg,
    input  logic                  ID_ALUSrc,
    input  logic [3:0]            ID_ALUOp,
    input  logic [DATA_WIDTH-1:0] ID_ReadData1,
    input  logic [DATA_WIDTH-1:0] ID_ReadData2,
    input  logic [DATA_WIDTH-1:0] ID_Imm,
    output logic                  EX_valid,
    output logic [4:0]            EXRegRs,
    output logic [4:0]            EXRegRt,
    output logic [4:0]            EXRegRd,
    output logic                  EX_RegWrite,
    output logic                  EX_MemRead,
    output logic                  EX_MemWrite,
    output logic                  EX_MemToReg,
    output logic                  EX_ALUSrc,
    output logic [3:0]            EX_ALUOp,
    output logic [DATA_WIDTH-1:0] EX_ReadData1,
    output logic [DATA_WIDTH-1:0] EX_ReadData2,
    output logic [DATA_WIDTH-1:0] EX_Imm,
    output logic                  PCWrite,
    output logic                  IFID_Write,
    output logic [CNT_WIDTH-1:0]  bubble_count,
    output logic [CNT_WIDTH-1:0]  flush_count
);

    typedef struct packed {
        logic                  valid;
        logic [4:0]            rs;
        logic [4:0]            rt;
        logic [4:0]            rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  alu_src;
        logic [3:0]            alu_op;
        logic [DATA_WIDTH-1:0] rd1;
        logic [DATA_WIDTH-1:0] rd2;
        logic [DATA_WIDTH-1:0] imm;
    } ex_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    ex_t  ex_q;
    ex_t  id_pkt;
    logic load_use;

    // An invalid ID slot loads as an all-zero bubble so stray control bits never reach EX.
    always_comb begin
        id_pkt = '0;
        if (ID_valid) begin
            id_pkt.valid      = 1'b1;
            id_pkt.rs         = ID_Rs;
            id_pkt.rt         = ID_Rt;
            id_pkt.rd         = ID_RegDst ? ID_Rd : ID_Rt;
            id_pkt.reg_write  = ID_RegWrite;
            id_pkt.mem_read   = ID_MemRead;
            id_pkt.mem_write  = ID_MemWrite;
            id_pkt.mem_to_reg = ID_MemToReg;
            id_pkt.alu_src    = ID_ALUSrc;
            id_pkt.alu_op     = ID_ALUOp;
            id_pkt.rd1        = ID_ReadData1;
            id_pkt.rd2        = ID_ReadData2;
            id_pkt.imm        = ID_Imm;
        end
    end

    assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & ID_valid &
                      ((ex_q.rd == ID_Rs) | (ex_q.rd == ID_Rt));

    assign PCWrite    = ~(load_use | stall_in);
    assign IFID_Write = ~(load_use | stall_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q         <= '0;
            bubble_count <= '0;
            flush_count  <= '0;
        end else if (stall_in) begin
            ex_q         <= ex_q;
        end else if (flush) begin
            ex_q <= '0;
            if (flush_count != CNT_MAX) flush_count <= flush_count + CNT_ONE;
        end else if (load_use) begin
            // The bubble clears EX mem_read, so the held instruction loads next edge.
            ex_q <= '0;
            if (bubble_count != CNT_MAX) bubble_count <= bubble_count + CNT_ONE;
        end else begin
            ex_q <= id_pkt;
        end
    end

    assign EX_valid     = ex_q.valid;
    assign EXRegRs      = ex_q.rs;
    assign EXRegRt      = ex_q.rt;
    assign EXRegRd      = ex_q.rd;
    assign EX_RegWrite  = ex_q.reg_write;
    assign EX_MemRead   = ex_q.mem_read;
    assign EX_MemWrite  = ex_q.mem_write;
    assign EX_MemToReg  = ex_q.mem_to_reg;
    assign EX_ALUSrc    = ex_q.alu_src;
    assign EX_ALUOp     = ex_q.alu_op;
    assign EX_ReadData1 = ex_q.rd1;
    assign EX_ReadData2 = ex_q.rd2;
    assign EX_Imm       = ex_q.imm;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table applied per cycle, expected EX state queued at drive and checked after the edge.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, stall_in, flush, ID_valid;
    logic [4:0]    ID_Rs, ID_Rt, ID_Rd;
    logic          ID_RegDst, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc;
    logic [3:0]    ID_ALUOp;
    logic [DW-1:0] ID_ReadData1, ID_ReadData2, ID_Imm;
    logic          EX_valid;
    logic [4:0]    EXRegRs, EXRegRt, EXRegRd;
    logic          EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc;
    logic [3:0]    EX_ALUOp;
    logic [DW-1:0] EX_ReadData1, EX_ReadData2, EX_Imm;
    logic          PCWrite, IFID_Write;
    logic [CW-1:0] bubble_count, flush_count;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush), .ID_valid(ID_valid),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
        .ID_RegDst(ID_RegDst), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
        .ID_MemWrite(ID_MemWrite), .ID_MemToReg(ID_MemToReg), .ID_ALUSrc(ID_ALUSrc),
        .ID_ALUOp(ID_ALUOp), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm),
        .EX_valid(EX_valid), .EXRegRs(EXRegRs), .EXRegRt(EXRegRt), .EXRegRd(EXRegRd),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
        .EX_MemToReg(EX_MemToReg), .EX_ALUSrc(EX_ALUSrc), .EX_ALUOp(EX_ALUOp),
        .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2), .EX_Imm(EX_Imm),
        .PCWrite(PCWrite), .IFID_Write(IFID_Write),
        .bubble_count(bubble_count), .flush_count(flush_count)
    );

    // ctl bit order: {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc}
    localparam logic [4:0] C_ALU = 5'b10000;
    localparam logic [4:0] C_LW  = 5'b11011;
    localparam logic [4:0] C_SW  = 5'b00101;
    localparam logic [4:0] C_ALL = 5'b11111;

    typedef struct packed {
        logic vld; logic [4:0] rs, rt, rd; logic regdst; logic [4:0] ctl;
        logic [3:0] aluop; logic [DW-1:0] d1, d2, imm;
    } id_t;

    typedef struct packed {
        logic vld; logic [4:0] rs, rt, rd; logic [4:0] ctl;
        logic [3:0] aluop; logic [DW-1:0] d1, d2, imm; logic [CW-1:0] bc, fc;
    } exp_t;

    typedef enum logic [1:0] {K_LOAD, K_BUB, K_HOLD} kind_t;

    typedef struct {
        logic rst, stall, flush; id_t id;
        logic pcw; kind_t kind; logic [4:0] xrd; logic [CW-1:0] bc, fc;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;

    function automatic id_t mkid(logic vld, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic regdst,
                                 logic [4:0] ctl, logic [3:0] op, logic [DW-1:0] d1, logic [DW-1:0] d2,
                                 logic [DW-1:0] imm);
        id_t r;
        r.vld = vld; r.rs = rs; r.rt = rt; r.rd = rd; r.regdst = regdst; r.ctl = ctl;
        r.aluop = op; r.d1 = d1; r.d2 = d2; r.imm = imm;
        return r;
    endfunction

    function automatic void addv(logic r, logic s, logic f, id_t id, logic pcw, kind_t k,
                                 logic [4:0] xrd, logic [CW-1:0] bc, logic [CW-1:0] fc);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f; v.id = id; v.pcw = pcw;
        v.kind = k; v.xrd = xrd; v.bc = bc; v.fc = fc;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        rst = v.rst; stall_in = v.stall; flush = v.flush;
        ID_valid = v.id.vld; ID_Rs = v.id.rs; ID_Rt = v.id.rt; ID_Rd = v.id.rd;
        ID_RegDst = v.id.regdst;
        {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc} = v.id.ctl;
        ID_ALUOp = v.id.aluop; ID_ReadData1 = v.id.d1; ID_ReadData2 = v.id.d2; ID_Imm = v.id.imm;
    endtask

    task automatic cmp_ex(exp_t e, int n);
        chk($sformatf("v%0d EX_valid", n), DW'(EX_valid), DW'(e.vld));
        chk($sformatf("v%0d EXRegRs", n), DW'(EXRegRs), DW'(e.rs));
        chk($sformatf("v%0d EXRegRt", n), DW'(EXRegRt), DW'(e.rt));
        chk($sformatf("v%0d EXRegRd", n), DW'(EXRegRd), DW'(e.rd));
        chk($sformatf("v%0d EX_ctl", n),
            DW'({EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemToReg, EX_ALUSrc}), DW'(e.ctl));
        chk($sformatf("v%0d EX_ALUOp", n), DW'(EX_ALUOp), DW'(e.aluop));
        chk($sformatf("v%0d EX_ReadData1", n), EX_ReadData1, e.d1);
        chk($sformatf("v%0d EX_ReadData2", n), EX_ReadData2, e.d2);
        chk($sformatf("v%0d EX_Imm", n), EX_Imm, e.imm);
        chk($sformatf("v%0d bubble_count", n), DW'(bubble_count), DW'(e.bc));
        chk($sformatf("v%0d flush_count", n), DW'(flush_count), DW'(e.fc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        id_t  a, b, lw5;
        int   bc;
        vec_t v0;
        exp_t e;

        v0.rst = 1'b1; v0.stall = 1'b0; v0.flush = 1'b0; v0.id = '0;
        drive(v0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset EX_valid", DW'(EX_valid), 0);
        chk("reset EX_MemRead", DW'(EX_MemRead), 0);
        chk("reset bubble_count", DW'(bubble_count), 0);
        chk("reset flush_count", DW'(flush_count), 0);
        chk("reset PCWrite", DW'(PCWrite), 1);
        last_exp = '0;

        addv(0, 0, 0, mkid(1, 2, 3, 4, 1, C_ALU, 4'h2, 'h11, 'h22, 'h33), 1, K_LOAD, 4, 0, 0);
        addv(0, 0, 0, mkid(1, 1, 5, 9, 0, C_LW, 4'h0, 'h100, 'h0, 'h8), 1, K_LOAD, 5, 0, 0);
        a = mkid(1, 5, 6, 7, 1, C_ALU, 4'h3, 'hAA, 'hBB, 'h0);
        addv(0, 0, 0, a, 0, K_BUB, 0, 1, 0);
        addv(0, 0, 0, a, 1, K_LOAD, 7, 1, 0);
        addv(0, 0, 0, mkid(1, 1, 8, 0, 0, C_LW, 4'h0, 'h200, 'h0, 'h4), 1, K_LOAD, 8, 1, 0);
        a = mkid(1, 8, 10, 0, 0, C_LW, 4'h0, 'h300, 'h0, 'hC);
        addv(0, 0, 0, a, 0, K_BUB, 0, 2, 0);
        addv(0, 0, 0, a, 1, K_LOAD, 10, 2, 0);
        a = mkid(1, 3, 10, 11, 1, C_ALU, 4'h1, 'h1, 'h2, 'h3);
        addv(0, 0, 0, a, 0, K_BUB, 0, 3, 0);
        addv(0, 0, 0, a, 1, K_LOAD, 11, 3, 0);
        addv(0, 0, 0, mkid(1, 1, 0, 0, 0, C_LW, 4'h0, 'h400, 'h0, 'h0), 1, K_LOAD, 0, 3, 0);
        addv(0, 0, 0, mkid(1, 0, 0, 12, 1, C_ALU, 4'h5, 'h5, 'h6, 'h7), 1, K_LOAD, 12, 3, 0);
        addv(0, 0, 0, mkid(0, 4, 5, 6, 1, C_ALL, 4'hF, 'hFFFF, 'hEEEE, 'hDDDD), 1, K_BUB, 0, 3, 0);
        addv(0, 0, 0, mkid(1, 2, 13, 0, 0, C_LW, 4'h0, 'h500, 'h0, 'h10), 1, K_LOAD, 13, 3, 0);
        a = mkid(1, 13, 1, 2, 1, C_ALU, 4'h6, 'h9, 'h9, 'h9);
        addv(0, 1, 1, a, 0, K_HOLD, 0, 3, 0);
        addv(0, 0, 1, a, 0, K_BUB, 0, 3, 1);
        addv(0, 0, 0, mkid(1, 2, 14, 0, 0, C_LW, 4'h0, 'h600, 'h0, 'h14), 1, K_LOAD, 14, 3, 1);
        addv(0, 0, 0, mkid(0, 14, 14, 3, 1, C_ALU, 4'h7, 'h1, 'h1, 'h1), 1, K_BUB, 0, 3, 1);
        addv(0, 0, 0, mkid(1, 1, 2, 3, 1, C_SW, 4'h8, 'hA5A5, 'h5A5A, 'h20), 1, K_LOAD, 3, 3, 1);
        b = mkid(1, 7, 7, 7, 1, C_ALU, 4'h9, 'h77, 'h77, 'h77);
        addv(0, 1, 0, b, 0, K_HOLD, 0, 3, 1);
        addv(0, 0, 1, b, 1, K_BUB, 0, 3, 2);

        // Self-dependent load held in ID alternates load/bubble until bubble_count saturates.
        lw5 = mkid(1, 5, 5, 9, 0, C_LW, 4'h0, 'h700, 'h0, 'h18);
        bc = 3;
        for (int i = 0; i < 18; i++) begin
            addv(0, 0, 0, lw5, 1, K_LOAD, 5, bc[CW-1:0], 2);
            bc = (bc < 15) ? bc + 1 : 15;
            addv(0, 0, 0, lw5, 0, K_BUB, 0, bc[CW-1:0], 2);
        end
        addv(0, 0, 0, lw5, 1, K_LOAD, 5, 15, 2);
        addv(1, 1, 0, lw5, 0, K_BUB, 0, 0, 0);
        addv(1, 0, 1, lw5, 1, K_BUB, 0, 0, 0);
        addv(0, 0, 0, lw5, 1, K_LOAD, 5, 0, 0);
        addv(0, 0, 0, lw5, 0, K_BUB, 0, 1, 0);

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge clk);
            drive(vecs[n]);
            #1;
            chk($sformatf("v%0d PCWrite", n), DW'(PCWrite), DW'(vecs[n].pcw));
            chk($sformatf("v%0d IFID_Write", n), DW'(IFID_Write), DW'(vecs[n].pcw));
            case (vecs[n].kind)
                K_LOAD: begin
                    e.vld = vecs[n].id.vld; e.rs = vecs[n].id.rs; e.rt = vecs[n].id.rt;
                    e.rd = vecs[n].xrd; e.ctl = vecs[n].id.ctl; e.aluop = vecs[n].id.aluop;
                    e.d1 = vecs[n].id.d1; e.d2 = vecs[n].id.d2; e.imm = vecs[n].id.imm;
                end
                K_HOLD:  e = last_exp;
                default: e = '0;
            endcase
            e.bc = vecs[n].bc;
            e.fc = vecs[n].fc;
            last_exp = e;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL v%0d scoreboard empty", n);
            end else begin
                cmp_ex(sb.pop_front(), n);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
